clock_set_ctrl: RTL and testbench

- Front-end controller that drives the time-of-day counter's set interface (set, sethms, upDown) from the board's three push-buttons.
- Debounces the keys, runs the RUN/SET_H/SET_M/SET_S mode machine, and issues single increment/decrement steps.
- Each step is aligned to the one-second tick, so the counter samples it on exactly one oneSecClk edge.
- Sits between the KEY inputs and the clock counter, in the fast system-clock domain.

---
 rtl/clock_set_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Purpose  : Push-button front end for the time-of-day counter set interface.
//            Debounces the three keys, walks the RUN/SET_H/SET_M/SET_S mode
//            machine and emits single up/down steps aligned to secTick so the
//            counter samples each step on exactly one oneSecClk edge.
// Ports    : clk      - system clock
//            reset    - synchronous, active-high reset
//            secTick  - one-cycle pulse at each oneSecClk rising edge
//            keyN     - raw active-low keys: [0]=mode, [1]=up, [2]=down
//            set      - high in any SET state
//            sethms   - field select: 00 hour, 01 min, 10 sec
//            upDown   - 10 up, 01 down, 00 idle
//            stepBusy - step engine not idle
// Options  : CLOCK_SET_AUTOREPEAT_EN - auto-repeat while up/down stays held
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
  parameter int DEB_CYCLES   = 1000000,
  parameter int REPEAT_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       secTick,
  input  logic [2:0] keyN,
  output logic       set,
  output logic [1:0] sethms,
  output logic [1:0] upDown,
  output logic       stepBusy
);

  localparam int            DW      = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, DRIVE = 2'd2} step_t;

  logic [2:0] key_pulse;
`ifdef CLOCK_SET_AUTOREPEAT_EN
  logic [2:0] key_pressed;
`endif

  // Per-key synchronizer + debouncer. Levels stay active-low internally so
  // the reset value (all ones) means "released".
  generate
    for (genvar k = 0; k < 3; k++) begin : g_key
      logic          sync1, sync2, deb_n, deb_n_d, pulse;
      logic [DW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1   <= 1'b1;
          sync2   <= 1'b1;
          deb_n   <= 1'b1;
          deb_n_d <= 1'b1;
          cnt     <= '0;
          pulse   <= 1'b0;
        end else begin
          sync1   <= keyN[k];
          sync2   <= sync1;
          deb_n_d <= deb_n;
          // Pulse lands one cycle after the debounced released->pressed flip.
          pulse   <= deb_n_d & ~deb_n;
          if (sync2 != deb_n) begin
            if (cnt == DEB_MAX) begin
              deb_n <= sync2;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
      end

      assign key_pulse[k] = pulse;
`ifdef CLOCK_SET_AUTOREPEAT_EN
      assign key_pressed[k] = ~deb_n;
`endif
    end
  endgenerate

  mode_t      mode_state, mode_next;
  step_t      step_state, step_next;
  logic       mode_pending, mode_pending_next;
  logic [1:0] dir, dir_next, updown_next;
  logic       step_done, engine_free, mode_go, up_p, dn_p, start, repeat_go;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int            RW      = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_DELAY);

  logic [RW-1:0] rep_cnt, rep_cnt_next;
  logic          dir_held, both_held;

  // Ticks are counted from the press while the key stays held; the current
  // tick is included so a repeat decision on a secTick cycle sees it.
  always_comb begin
    dir_held     = (dir == 2'b10) ? key_pressed[1] : key_pressed[2];
    both_held    = key_pressed[1] & key_pressed[2];
    rep_cnt_next = rep_cnt;
    if (start) begin
      rep_cnt_next = '0;
    end else if ((step_state != IDLE) && secTick && dir_held && (rep_cnt != REP_MAX)) begin
      rep_cnt_next = rep_cnt + 1'b1;
    end
    repeat_go = (rep_cnt_next >= REP_MAX) && dir_held && !both_held &&
                !key_pulse[0] && !mode_pending;
  end

  always_ff @(posedge clk) begin
    if (reset) rep_cnt <= '0;
    else       rep_cnt <= rep_cnt_next;
  end
`else
  assign repeat_go = 1'b0;
`endif

  always_comb begin
    // Mode changes are only allowed when upDown is about to be (or is) idle.
    step_done   = (step_state == DRIVE) && secTick;
    engine_free = (step_state == IDLE) || step_done;
    mode_go     = (key_pulse[0] || mode_pending) && engine_free;

    mode_next = mode_state;
    if (mode_go) begin
      case (mode_state)
        RUN:     mode_next = SET_H;
        SET_H:   mode_next = SET_M;
        SET_M:   mode_next = SET_S;
        default: mode_next = RUN;
      endcase
    end

    mode_pending_next = mode_pending;
    if (mode_go)           mode_pending_next = 1'b0;
    else if (key_pulse[0]) mode_pending_next = 1'b1;

    // A mode change wins over a coincident step request.
    up_p  = key_pulse[1] & ~key_pulse[2];
    dn_p  = key_pulse[2] & ~key_pulse[1];
    start = (step_state == IDLE) && (mode_state != RUN) && (up_p || dn_p) && !mode_go;

    step_next   = step_state;
    dir_next    = dir;
    updown_next = upDown;
    case (step_state)
      IDLE: begin
        if (start) begin
          step_next = ARM;
          dir_next  = up_p ? 2'b10 : 2'b01;
        end
      end
      ARM: begin
        if (secTick) begin
          step_next   = DRIVE;
          updown_next = dir;
        end
      end
      DRIVE: begin
        if (secTick) begin
          step_next   = repeat_go ? ARM : IDLE;
          updown_next = 2'b00;
        end
      end
      default: begin
        step_next   = IDLE;
        updown_next = 2'b00;
      end
    endcase

    set      = (mode_state != RUN);
    stepBusy = (step_state != IDLE);
    case (mode_state)
      SET_M:   sethms = 2'b01;
      SET_S:   sethms = 2'b10;
      default: sethms = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_state   <= RUN;
      step_state   <= IDLE;
      mode_pending <= 1'b0;
      dir          <= 2'b00;
      upDown       <= 2'b00;
    end else begin
      mode_state   <= mode_next;
      step_state   <= step_next;
      mode_pending <= mode_pending_next;
      dir          <= dir_next;
      upDown       <= updown_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Purpose  : Directed self-checking bench for clock_set_ctrl (DEB_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset, secTick;
  logic [2:0] keyN;
  logic       set, stepBusy;
  logic [1:0] sethms, upDown;

  int vectors     = 0;
  int miscompares = 0;
  int up_hits     = 0;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int HELD_STEPS = 5;
`else
  localparam int HELD_STEPS = 1;
`endif

  always #5 clk = ~clk;

  clock_set_ctrl #(.DEB_CYCLES(4), .REPEAT_DELAY(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .secTick  (secTick),
    .keyN     (keyN),
    .set      (set),
    .sethms   (sethms),
    .upDown   (upDown),
    .stepBusy (stepBusy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle secTick; records whether the counter would see an up step.
  task automatic sec_tick();
    if (upDown == 2'b10) up_hits++;
    secTick = 1'b1;
    tick();
    secTick = 1'b0;
  endtask

  task automatic press_key(input int k);
    keyN[k] = 1'b0;
    wait_n(10);
    keyN[k] = 1'b1;
    wait_n(10);
  endtask

  initial begin
    reset   = 1'b1;
    secTick = 1'b0;
    keyN    = 3'b111;
    wait_n(3);
    check("rst_set", {7'd0, set}, 8'd0);
    check("rst_sethms", {6'd0, sethms}, 8'd0);
    check("rst_updown", {6'd0, upDown}, 8'd0);
    check("rst_busy", {7'd0, stepBusy}, 8'd0);
    reset = 1'b0;
    tick();
    check("post_rst_set", {7'd0, set}, 8'd0);

    // Mode press latency: pulse after 7 edges, mode register one edge later.
    keyN[0] = 1'b0;
    wait_n(7);
    check("mode_lat_early", {7'd0, set}, 8'd0);
    tick();
    check("mode_lat_set", {7'd0, set}, 8'd1);
    check("mode_lat_hms", {6'd0, sethms}, 8'd0);
    keyN[0] = 1'b1;
    wait_n(10);

    // Bouncing up key in SET_H must not start a step.
    for (int i = 0; i < 5; i++) begin
      keyN[1] = 1'b0;
      wait_n(2);
      keyN[1] = 1'b1;
      wait_n(2);
    end
    wait_n(10);
    check("bounce_busy", {7'd0, stepBusy}, 8'd0);
    check("bounce_updown", {6'd0, upDown}, 8'd0);

    press_key(0);
    check("setm_hms", {6'd0, sethms}, 8'h01);

    // Single up step in SET_M.
    press_key(1);
    check("arm_busy", {7'd0, stepBusy}, 8'd1);
    check("arm_updown", {6'd0, upDown}, 8'd0);
    up_hits = 0;
    sec_tick();
    check("drive_updown", {6'd0, upDown}, 8'h02);
    wait_n(3);
    check("drive_hold", {6'd0, upDown}, 8'h02);
    check("drive_busy", {7'd0, stepBusy}, 8'd1);
    sec_tick();
    check("done_updown", {6'd0, upDown}, 8'd0);
    check("done_busy", {7'd0, stepBusy}, 8'd0);
    wait_n(2);
    sec_tick();
    wait_n(2);
    check("idle_tick_busy", {7'd0, stepBusy}, 8'd0);
    check("one_edge_hit", up_hits[7:0], 8'd1);
    check("step_hms_kept", {6'd0, sethms}, 8'h01);

    // Two mode presses during DRIVE: one advance, on the return to IDLE.
    press_key(1);
    sec_tick();
    check("drive2_updown", {6'd0, upDown}, 8'h02);
    press_key(0);
    press_key(0);
    check("pend_hms_hold", {6'd0, sethms}, 8'h01);
    check("pend_updown", {6'd0, upDown}, 8'h02);
    sec_tick();
    check("pend_updown_end", {6'd0, upDown}, 8'd0);
    check("pend_busy_end", {7'd0, stepBusy}, 8'd0);
    check("pend_hms_adv", {6'd0, sethms}, 8'h02);
    wait_n(3);
    check("pend_once", {6'd0, sethms}, 8'h02);

    press_key(0);
    check("wrap_set", {7'd0, set}, 8'd0);
    check("wrap_hms", {6'd0, sethms}, 8'd0);

    // Down press in RUN is ignored.
    press_key(2);
    check("run_down_busy", {7'd0, stepBusy}, 8'd0);
    sec_tick();
    check("run_down_updown", {6'd0, upDown}, 8'd0);

    // Simultaneous up+down in SET_H is ignored.
    press_key(0);
    keyN = 3'b001;
    wait_n(10);
    keyN = 3'b111;
    wait_n(10);
    check("both_busy", {7'd0, stepBusy}, 8'd0);

    // Reset in the middle of a down step.
    press_key(2);
    sec_tick();
    check("down_updown", {6'd0, upDown}, 8'h01);
    check("down_set", {7'd0, set}, 8'd1);
    reset = 1'b1;
    tick();
    check("midrst_updown", {6'd0, upDown}, 8'd0);
    check("midrst_set", {7'd0, set}, 8'd0);
    check("midrst_hms", {6'd0, sethms}, 8'd0);
    check("midrst_busy", {7'd0, stepBusy}, 8'd0);
    reset = 1'b0;
    tick();

    // Up key held across ten secTicks in SET_H.
    press_key(0);
    keyN[1] = 1'b0;
    wait_n(10);
    up_hits = 0;
    for (int i = 0; i < 10; i++) begin
      sec_tick();
      wait_n(3);
    end
    check("held_steps", up_hits[7:0], HELD_STEPS[7:0]);
    keyN[1] = 1'b1;
    wait_n(10);
    sec_tick();
    wait_n(2);
    sec_tick();
    wait_n(2);
    check("held_release_busy", {7'd0, stepBusy}, 8'd0);
    check("held_release_updown", {6'd0, upDown}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
